// File: rtl/piso_shift_reg.sv
// ----------------------------------------------------------------------------
// piso_shift_reg
//
// Parallel-in, serial-out shift register with a valid/ready load handshake
// and a one-word holding buffer, so consecutive words stream out with no
// idle cycle between them.
//
// Parameters
//   WIDTH     : bits per word (2..32)
//   MSB_FIRST : 1 = P[WIDTH-1] leaves first, 0 = P[0] leaves first
//
// Ports
//   C    in   clock, all state changes on the rising edge
//   R    in   synchronous active-high reset
//   P    in   parallel word, sampled only when a load is accepted
//   LD   in   load request
//   RDY  out  a load is accepted on an edge with LD=1 and RDY=1
//   Q    out  serial data bit (0 while idle)
//   QV   out  Q carries a valid data bit this cycle
//   LAST out  Q is the final bit of the current word
// ----------------------------------------------------------------------------
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] P,
    input  logic             LD,
    output logic             RDY,
    output logic             Q,
    output logic             QV,
    output logic             LAST
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hb_q, hb_d;
    logic             hf_q, hf_d;

    logic             accept_s;
    logic             last_s;
    logic             active_bit_s;

    // Move SR one place toward the end that drives Q, filling with zero.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {v[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, v[WIDTH-1:1]};
        end
        return r;
    endfunction

    // The buffer is the only thing that can refuse a word: SR always has room
    // either because we are idle or because its last bit leaves this edge.
    assign RDY      = ~hf_q;
    assign accept_s = LD & ~hf_q;

    assign last_s       = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign active_bit_s = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

    // Serial outputs decoded from registered state only.
    assign QV   = (state_q == ST_SHIFT);
    assign Q    = (state_q == ST_SHIFT) ? active_bit_s : 1'b0;
    assign LAST = last_s;

    // Next-state logic for the FSM, shift register, counter and buffer.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        hb_d    = hb_q;
        hf_d    = hf_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    sr_d    = P;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (!last_s) begin
                    sr_d  = shift_one(sr_q);
                    cnt_d = cnt_q + CW'(1);
                    if (accept_s) begin
                        hb_d = P;
                        hf_d = 1'b1;
                    end else begin
                        hb_d = hb_q;
                    end
                end else if (hf_q) begin
                    // Buffered word follows the last bit with no gap.
                    sr_d  = hb_q;
                    hf_d  = 1'b0;
                    cnt_d = '0;
                end else if (accept_s) begin
                    // Word arriving during the last bit goes straight to SR.
                    sr_d  = P;
                    cnt_d = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                hf_d    = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that discards any word in flight.
    always_ff @(posedge C) begin
        if (R) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            hb_q    <= '0;
            hf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            hb_q    <= hb_d;
            hf_q    <= hf_d;
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_piso_shift_reg
//
// Three instances run side by side: WIDTH=4 MSB-first, WIDTH=4 LSB-first and
// WIDTH=2 MSB-first. The reference model treats each transmitter as a queue of
// pending (last, bit) pairs: the head is what Q shows this cycle, a load is
// possible while no more than one word is queued, and every edge retires the
// head and appends an accepted word.
// ----------------------------------------------------------------------------
module tb_piso_shift_reg;

    logic       clk = 1'b0;
    logic [2:0] r_s;
    logic [2:0] ld_s;
    logic [3:0] p0_s;
    logic [3:0] p1_s;
    logic [1:0] p2_s;
    logic [2:0] rdy_o;
    logic [2:0] q_o;
    logic [2:0] qv_o;
    logic [2:0] last_o;

    logic [1:0] mq [3][$];
    int n_assert = 0;
    int n_fail   = 0;

    // 10 time-unit clock.
    always #5 clk = ~clk;

    piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m4 (
        .C(clk), .R(r_s[0]), .P(p0_s), .LD(ld_s[0]),
        .RDY(rdy_o[0]), .Q(q_o[0]), .QV(qv_o[0]), .LAST(last_o[0])
    );

    piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l4 (
        .C(clk), .R(r_s[1]), .P(p1_s), .LD(ld_s[1]),
        .RDY(rdy_o[1]), .Q(q_o[1]), .QV(qv_o[1]), .LAST(last_o[1])
    );

    piso_shift_reg #(.WIDTH(2), .MSB_FIRST(1'b1)) dut_m2 (
        .C(clk), .R(r_s[2]), .P(p2_s), .LD(ld_s[2]),
        .RDY(rdy_o[2]), .Q(q_o[2]), .QV(qv_o[2]), .LAST(last_o[2])
    );

    function automatic int wid(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic bit msb(input int i);
        return (i != 1);
    endfunction

    task automatic check(input string tag, input int i, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d t=%0t: observed %b expected %b", tag, i, $time, obs, exp);
        end
    endtask

    // Check the cycle now showing, then drive inputs for the next edge and
    // advance the model across that edge.
    task automatic tick(input logic [2:0] r, input logic [2:0] ld,
                        input logic [3:0] pa, input logic [3:0] pb, input logic [1:0] pc);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic ev, eq, el, er;
            ev = (mq[i].size() > 0);
            eq = ev ? mq[i][0][0] : 1'b0;
            el = ev ? mq[i][0][1] : 1'b0;
            er = (mq[i].size() <= wid(i));
            check("Q",    i, q_o[i],    eq);
            check("QV",   i, qv_o[i],   ev);
            check("LAST", i, last_o[i], el);
            check("RDY",  i, rdy_o[i],  er);
        end
        r_s  = r;
        ld_s = ld;
        p0_s = pa;
        p1_s = pb;
        p2_s = pc;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [3:0] pw;
            logic       acc;
            int         w;
            w  = wid(i);
            pw = (i == 0) ? pa : (i == 1) ? pb : {2'b00, pc};
            if (r[i]) begin
                mq[i].delete();
            end else begin
                acc = ld[i] && (mq[i].size() <= w);
                if (mq[i].size() > 0) void'(mq[i].pop_front());
                if (acc) begin
                    for (int k = 0; k < w; k++) begin
                        int idx;
                        idx = msb(i) ? (w - 1 - k) : k;
                        mq[i].push_back({(k == w - 1), pw[idx]});
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick(3'b000, 3'b000, 4'h0, 4'h0, 2'b00);
    endtask

    initial begin
        // Reset held with a load request pending: nothing may be accepted.
        r_s  = 3'b111;
        ld_s = 3'b111;
        p0_s = 4'hF;
        p1_s = 4'hF;
        p2_s = 2'b11;
        repeat (2) @(posedge clk);
        tick(3'b111, 3'b111, 4'hF, 4'hF, 2'b11);
        idle(2);

        // Single word, MSB first.
        tick(3'b000, 3'b001, 4'b1011, 4'h0, 2'b00);
        idle(6);

        // Back-to-back: second word accepted on the second shift cycle.
        tick(3'b000, 3'b001, 4'b1010, 4'h0, 2'b00);
        idle(1);
        tick(3'b000, 3'b001, 4'b0110, 4'h0, 2'b00);
        idle(9);

        // Bypass load during the LAST cycle.
        tick(3'b000, 3'b001, 4'b1100, 4'h0, 2'b00);
        idle(3);
        tick(3'b000, 3'b001, 4'b0011, 4'h0, 2'b00);
        idle(6);

        // LSB first with backpressure on a third word.
        tick(3'b000, 3'b010, 4'h0, 4'b1011, 2'b00);
        tick(3'b000, 3'b010, 4'h0, 4'b0001, 2'b00);
        tick(3'b000, 3'b010, 4'h0, 4'hF, 2'b00);
        tick(3'b000, 3'b010, 4'h0, 4'hF, 2'b00);
        idle(10);

        // Reset mid-word with the buffer full, then a fresh word.
        tick(3'b000, 3'b101, 4'b1001, 4'h0, 2'b10);
        tick(3'b000, 3'b101, 4'b0101, 4'h0, 2'b01);
        tick(3'b101, 3'b000, 4'h0, 4'h0, 2'b00);
        tick(3'b000, 3'b101, 4'b0110, 4'h0, 2'b10);
        idle(7);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] rr;
            rr[0] = ($urandom_range(0, 39) == 0);
            rr[1] = ($urandom_range(0, 39) == 0);
            rr[2] = ($urandom_range(0, 39) == 0);
            tick(rr, 3'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
- Parallel-in, serial-out shift register: the transmit-side counterpart of the team's serial-in/parallel-out D-flip-flop shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per clock on a serial data line, with valid and last-bit qualifiers.
- A one-word holding buffer allows back-to-back words with no idle gap.
- Feeds the serial D input of the receive-side shift register chain.

Parameters:
- WIDTH, 4: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = shift P[WIDTH-1] first; 0 = shift P[0] first.

Ports:
- C  input  1  clock; all state changes on the rising edge.
- R  input  1  reset; synchronous, active-high.
- P  input  WIDTH  parallel word to transmit.
- LD  input  1  load request; P is valid while LD=1.
- RDY  output  1  ready for a load; a word is accepted on an edge where LD=1 and RDY=1.
- Q  output  1  serial data bit.
- QV  output  1  Q is a valid data bit this cycle.
- LAST  output  1  Q is the final bit of the current word.

Behaviour:
- Reset, at the first rising edge with R=1:
  - Q=0, QV=0, LAST=0, RDY=1.
  - Bit counter = 0; holding buffer empty (HF=0); state = IDLE.
  - R overrides every other input, including a simultaneous LD.
- State:
  - Shift register SR (WIDTH bits), bit counter CNT (clog2(WIDTH) bits).
  - Holding register HB (WIDTH bits) with full flag HF.
  - FSM states: IDLE, SHIFT.
- RDY = ~HF, combinational from HF only.
  - RDY=1 in IDLE and in SHIFT while HF=0.
- Outputs:
  - Q: the active end of SR (SR[WIDTH-1] if MSB_FIRST, else SR[0]) while in SHIFT; 0 in IDLE.
  - QV = 1 in SHIFT, 0 in IDLE.
  - LAST = 1 when in SHIFT and CNT == WIDTH-1.
- IDLE:
  - On accept: SR <= P, CNT <= 0, go to SHIFT.
  - The first bit appears on Q with QV=1 in the cycle immediately after the accepting edge (latency 1 clock).
- SHIFT, edge with LAST=0:
  - SR shifts by one toward the active end; zero fill at the other end.
  - CNT increments.
  - An accept in this cycle writes P into HB and sets HF=1.
- SHIFT, edge with LAST=1:
  - If HF=1: SR <= HB, HF <= 0, CNT <= 0, stay in SHIFT.
  - Else, if an accept occurs on this edge: SR <= P (bypass, HB untouched), CNT <= 0, stay in SHIFT.
  - Else: go to IDLE, CNT <= 0.
  - In both continuing cases the next word's first bit follows the previous LAST bit with no gap (QV stays 1).
- LD=1 while RDY=0: ignored; P is not sampled and no state changes.
- HF and a new accept cannot coincide, because RDY=0 whenever HF=1.
- Reset mid-word: the current word and any HB content are discarded. The cycle after the reset edge shows QV=0, LAST=0, RDY=1. No partial-word bits are emitted afterwards.
- P changes while not accepted: no effect.
- SR contents are don't-care in IDLE; Q must still read 0.

Test Plan:
- Reset: hold R=1 for 2 cycles with LD=1, P=4'hF -> Q=0, QV=0, LAST=0, RDY=1 after the reset edge; no word accepted.
- Single word (MSB_FIRST=1): accept P=4'b1011 -> next 4 cycles show Q=1,0,1,1 with QV=1 and LAST=0,0,0,1; QV=0 in the 5th cycle; RDY stays 1 throughout.
- Back-to-back: accept 4'b1010, then accept 4'b0110 on the 2nd shift cycle -> 8 contiguous QV=1 cycles with Q=1,0,1,0,0,1,1,0 and LAST high on cycles 4 and 8. RDY=0 from the second accept until the edge that moves HB into SR.
- Bypass load: accept 4'b1100, then first assert LD with P=4'b0011 in the LAST cycle -> Q=1,1,0,0,0,0,1,1 with no gap; HF never set.
- Backpressure and LSB-first (MSB_FIRST=0):
  - Accept 4'b1011 and 4'b0001; attempt a third load of 4'hF while RDY=0.
  - Required stream: Q=1,1,0,1,1,0,0,0, then QV=0; 4'hF never appears.
- Reset mid-word (WIDTH=2, then WIDTH=4): assert R after 2 emitted bits of 4'b1001 while HB holds 4'b0101 -> QV=0, RDY=1 next cycle. A fresh accept of 4'b0110 then yields exactly Q=0,1,1,0.
